irq_sched: RTL
==============

Name: irq_sched

Overview:
- Interrupt and vector scheduler for the 65C02 core. It arbitrates between reset, NMI, IRQ and BRK.
- At each instruction boundary (`sync`) it tells the microcode controller whether to inject an interrupt sequence. It also tells it which register-file vector index to drive onto ABL and which B value to push.
- It holds the chosen vector stable until the controller acknowledges the vector fetch.
- It replaces the ad-hoc IRQ gating in the controller and adds proper NMI edge handling.

Parameters:
- RST_VEC, 9, register-file index of the reset vector low byte ($FC)
- NMI_VEC, 8, register-file index of the NMI vector low byte ($FA)
- IRQ_VEC, 4, register-file index of the IRQ vector low byte ($FE)
- BRK_VEC, 10, register-file index of the BRK vector low byte ($FE)

Ports:
- clk  in  1  CPU clock
- RST_N  in  1  synchronous active-low reset
- IRQ  in  1  interrupt request, level, active high
- NMI  in  1  non-maskable interrupt, rising-edge triggered
- sync  in  1  controller at instruction boundary (opcode on DB this cycle)
- DB  in  8  data bus input (opcode when `sync`=1)
- I  in  1  current I flag
- ack  in  1  controller has fetched the vector low byte; 1-cycle pulse
- take  out  1  inject interrupt sequence instead of executing opcode
- vec  out  4  vector register index
- B  out  1  B bit for pushed P
- busy  out  1  service in progress (locked)
- err  out  1  sticky protocol error

Behaviour:
- One clock (`clk`). Reset is synchronous, active-low (`RST_N`). All state registers update on the `posedge clk` only.
- Reset (`RST_N`=0):
  - State = IDLE.
  - `rst_pend`=1, `nmi_pend`=0.
  - `nmi_q`=1, so an NMI held high through reset does not cause an edge.
  - Locked vector = RST_VEC, `B`=0, `err`=0.
  - A reset asserted mid-service aborts the service immediately. No `ack` is needed.
- NMI edge detection:
  - `nmi_q` <= NMI every cycle.
  - `edge` = NMI & ~`nmi_q`.
  - `nmi_pend` is set by `edge` and cleared by `ack` while the locked vector is NMI_VEC.
  - Set wins over a simultaneous clear, so a new edge during the NMI acknowledge is not lost.
- Candidate selection, combinational, priority order:
  - `rst_pend` -> RST_VEC
  - else `nmi_pend` -> NMI_VEC
  - else (IRQ & ~I) -> IRQ_VEC
- State machine: IDLE, SERVICE.
- IDLE:
  - `take` = `rst_pend` | `nmi_pend` | (IRQ & ~I). It is valid only when `sync`=1; the controller ignores it otherwise.
  - `vec` = candidate, or BRK_VEC if no candidate. `B` = ~`take`. `busy`=0.
  - On `sync` & `take`: lock candidate, `B`=0, go to SERVICE.
  - On `sync` & ~`take` & (DB==8'h00): lock BRK_VEC, `B`=1, go to SERVICE (BRK).
  - An interrupt takes priority over a BRK opcode on the same `sync`. The opcode is discarded, not re-executed.
- SERVICE:
  - `take`=0, `busy`=1. `vec` and `B` are held at the locked values.
  - Late NMI edges only set `nmi_pend`; there is no vector hijack.
  - On `ack`: clear the pending source (`rst_pend` for RST_VEC, `nmi_pend` for NMI_VEC), go to IDLE.
  - IRQ is level-sensitive and is never latched.
- `err` is set, and sticky until reset, on either of:
  - `sync` in SERVICE
  - `ack` in IDLE
- An `ack` in IDLE has no other effect.
- Latency:
  - NMI rising edge at cycle t -> `nmi_pend` at t+1. It is taken at the first `sync` at or after t+1.
  - IRQ is sampled combinationally at `sync`. Because I is updated at `sync`, an SEI executing now masks IRQ from the next boundary on.
- RST has no NMI/IRQ interaction: NMI edges during the reset service are remembered and taken at the next `sync` after `ack`.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined:
  - IRQ and NMI each pass through a 2-flop synchronizer before any other logic. Both flops reset to 0 for IRQ and 1 for NMI.
  - This adds 2 cycles to all interrupt latencies.
- Undefined:
  - Inputs are used directly; the inputs are assumed synchronous to `clk`.

Test Plan:
- Reset release: `RST_N` 0->1, first `sync` -> `take`=1, `vec`=9, `B`=0. After `ack`: `take`=0 and `busy`=0 on the following `sync` with IRQ=0.
- BRK: `sync` with DB=8'h00, IRQ=0, no pending -> `take`=0, then `busy`=1, `vec`=10, `B`=1 held until `ack`.
- IRQ masking: IRQ=1 at `sync`:
  - I=1 -> `take`=0
  - I=0 -> `take`=1, `vec`=4, `B`=0
- NMI priority and edge: NMI 0->1 and IRQ=1, I=0 before `sync` -> `vec`=8. NMI held high afterwards: after `ack`, next `sync` gives `vec`=4 (IRQ), not 8.
- NMI during NMI ack: second NMI rising edge in the same cycle as `ack` -> `nmi_pend` stays 1 and the next `sync` gives `take`=1, `vec`=8.
- Mid-service reset and errors:
  - `RST_N`=0 while `busy`=1 -> `busy`=0, next `sync` `vec`=9.
  - Separately, `ack` in IDLE -> `err`=1 until reset.
  - With IRQ_SYNC_EN, IRQ latency measured as 2 cycles longer.

Source files
------------

// File: rtl/irq_sched.sv
// Interrupt/vector scheduler for the 65C02 core: arbitrates reset, NMI, IRQ and BRK
// at instruction boundaries. Define IRQ_SYNC_EN to add 2-flop input synchronizers on IRQ/NMI.
module irq_sched #(
    parameter logic [3:0] RST_VEC = 4'd9,
    parameter logic [3:0] NMI_VEC = 4'd8,
    parameter logic [3:0] IRQ_VEC = 4'd4,
    parameter logic [3:0] BRK_VEC = 4'd10
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic       IRQ,
    input  logic       NMI,
    input  logic       sync,
    input  logic [7:0] DB,
    input  logic       I,
    input  logic       ack,
    output logic       take,
    output logic [3:0] vec,
    output logic       B,
    output logic       busy,
    output logic       err
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_t;

    state_t     state_r, state_n;
    logic       rst_pend_r, rst_pend_n;
    logic       nmi_pend_r, nmi_pend_n;
    logic       nmi_q_r;
    logic [3:0] lock_vec_r, lock_vec_n;
    logic       lock_b_r, lock_b_n;
    logic       err_r, err_n;
    logic       irq_s, nmi_s;
    logic       irq_req_s, nmi_edge_s, nmi_clr_s;
    logic       cand_valid_s;
    logic [3:0] cand_vec_s;

`ifdef IRQ_SYNC_EN
    logic [1:0] irq_sync_r, nmi_sync_r;

    // Two-stage synchronizers; NMI resets high so a held NMI is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            irq_sync_r <= 2'b00;
            nmi_sync_r <= 2'b11;
        end else begin
            irq_sync_r <= {irq_sync_r[0], IRQ};
            nmi_sync_r <= {nmi_sync_r[0], NMI};
        end
    end

    assign irq_s = irq_sync_r[1];
    assign nmi_s = nmi_sync_r[1];
`else
    assign irq_s = IRQ;
    assign nmi_s = NMI;
`endif

    // Candidate source selection in fixed priority: reset, NMI, unmasked IRQ.
    always_comb begin
        irq_req_s  = irq_s & ~I;
        nmi_edge_s = nmi_s & ~nmi_q_r;
        if (rst_pend_r) begin
            cand_valid_s = 1'b1;
            cand_vec_s   = RST_VEC;
        end else if (nmi_pend_r) begin
            cand_valid_s = 1'b1;
            cand_vec_s   = NMI_VEC;
        end else if (irq_req_s) begin
            cand_valid_s = 1'b1;
            cand_vec_s   = IRQ_VEC;
        end else begin
            cand_valid_s = 1'b0;
            cand_vec_s   = BRK_VEC;
        end
    end

    // Next-state logic: lock a vector at the boundary, release it on ack.
    always_comb begin
        state_n    = state_r;
        rst_pend_n = rst_pend_r;
        lock_vec_n = lock_vec_r;
        lock_b_n   = lock_b_r;
        err_n      = err_r;
        nmi_clr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ack) begin
                    err_n = 1'b1;
                end else begin
                    err_n = err_r;
                end
                // An interrupt wins over a BRK opcode fetched on the same boundary.
                if (sync && cand_valid_s) begin
                    lock_vec_n = cand_vec_s;
                    lock_b_n   = 1'b0;
                    state_n    = ST_SERVICE;
                end else if (sync && (DB == 8'h00)) begin
                    lock_vec_n = BRK_VEC;
                    lock_b_n   = 1'b1;
                    state_n    = ST_SERVICE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (sync) begin
                    err_n = 1'b1;
                end else begin
                    err_n = err_r;
                end
                if (ack) begin
                    state_n = ST_IDLE;
                    if (lock_vec_r == RST_VEC) begin
                        rst_pend_n = 1'b0;
                    end else if (lock_vec_r == NMI_VEC) begin
                        nmi_clr_s = 1'b1;
                    end else begin
                        nmi_clr_s = 1'b0;
                    end
                end else begin
                    state_n = ST_SERVICE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        // A fresh edge beats a simultaneous acknowledge so it is never lost.
        nmi_pend_n = nmi_edge_s | (nmi_pend_r & ~nmi_clr_s);
    end

    // State and pending-source registers.
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state_r    <= ST_IDLE;
            rst_pend_r <= 1'b1;
            nmi_pend_r <= 1'b0;
            nmi_q_r    <= 1'b1;
            lock_vec_r <= RST_VEC;
            lock_b_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            rst_pend_r <= rst_pend_n;
            nmi_pend_r <= nmi_pend_n;
            nmi_q_r    <= nmi_s;
            lock_vec_r <= lock_vec_n;
            lock_b_r   <= lock_b_n;
            err_r      <= err_n;
        end
    end

    assign take = (state_r == ST_IDLE) & cand_valid_s;
    assign vec  = (state_r == ST_IDLE) ? cand_vec_s : lock_vec_r;
    assign B    = (state_r == ST_IDLE) ? ~cand_valid_s : lock_b_r;
    assign busy = (state_r == ST_SERVICE);
    assign err  = err_r;

endmodule
